// File: rtl/period_meter.sv
// period_meter: measures the rising-to-rising period of an async input in clk
// cycles and reports it with a one-cycle valid pulse.
// Ports: clk, rst (async high), en, sig_in (async) ->
//        period, high_time, period_valid (pulse), timeout (sticky).
// Option: define PERIOD_METER_HIGH_TIME_EN to measure high cycles per period;
//         otherwise high_time is tied to 0.
module period_meter #(
   parameter int          WIDTH     = 16,
   parameter int unsigned MAX_COUNT = (1 << WIDTH) - 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sig_in,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] high_time,
   output logic             period_valid,
   output logic             timeout
);

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic             s1_q, s2_q, s3_q;
   logic             rise;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;

   // s1/s2 resynchronise sig_in; s3 is the history used for edge detect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= sig_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise = s2_q & ~s3_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         period_q  <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
      end
   end

   // Priority in RUN: disable, then a rise (even on the timeout cycle),
   // then timeout, then plain counting.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      valid_d   = 1'b0;
      timeout_d = timeout_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (rise && en) begin
               state_d = RUN;
               cnt_d   = ONE;
            end
         end
         RUN: begin
            if (!en) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (rise) begin
               period_d  = cnt_q;
               valid_d   = 1'b1;
               cnt_d     = ONE;
               timeout_d = 1'b0;
            end else if (cnt_q == MAX_C) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

`ifdef PERIOD_METER_HIGH_TIME_EN
   logic [WIDTH-1:0] hcnt_q, hcnt_d;
   logic [WIDTH-1:0] high_q, high_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcnt_q <= '0;
         high_q <= '0;
      end else begin
         hcnt_q <= hcnt_d;
         high_q <= high_d;
      end
   end

   // The rise cycle itself is high, hence the restart value of 1.
   always_comb begin
      hcnt_d = hcnt_q;
      high_d = high_q;
      if (valid_d)
         high_d = hcnt_q;
      if (rise)
         hcnt_d = ONE;
      else if (s2_q && hcnt_q != MAX_C)
         hcnt_d = hcnt_q + ONE;
   end

   assign high_time = high_q;
`else
   assign high_time = '0;
`endif

   assign period       = period_q;
   assign period_valid = valid_q;
   assign timeout      = timeout_q;

endmodule
